avr_gpio_port: RTL and testbench

AVR_GPIO_PORT -- requirements
Module: avr_gpio_port

---
 rtl/avr_io_pkg.sv | 15 +
 rtl/avr_sync2.sv | 26 ++
 rtl/avr_gpio_port.sv | 112 +++++++++++
 tb/tb_avr_gpio_port.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_io_pkg.sv
// Register map shared by the GPIO port and the chip-level wrappers that
// instantiate one port per letter.
package avr_io_pkg;

  localparam logic [2:0] IO_PIN   = 3'd0;
  localparam logic [2:0] IO_DDR   = 3'd1;
  localparam logic [2:0] IO_PORT  = 3'd2;
  localparam logic [2:0] IO_PCMSK = 3'd3;
  localparam logic [2:0] IO_PCIF  = 3'd4;

  function automatic logic io_is_mapped(input logic [2:0] a);
    return (a <= IO_PCIF);
  endfunction

endpackage

// File: rtl/avr_sync2.sv
// Two-flop synchronizer for asynchronous pad levels; q_o is the second stage.
module avr_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/avr_gpio_port.sv
// AVR-style GPIO port: PIN/DDR/PORT registers, pull-up control and a
// pin-change interrupt flag with a per-bit mask.
module avr_gpio_port
  import avr_io_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PIN_MASK  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_DDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             pud,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] pad_pullup,
  output logic             pcint_irq
);

  logic [WIDTH-1:0] sync_pin;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] port_q, port_d;
  logic [WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic             pcif_q, pcif_d;
  logic             pcif_clr;
  logic             pc_hit;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  avr_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pad_in),
    .q_o (sync_pin)
  );

  assign pin = sync_pin & PIN_MASK;

  // prev_vld_q keeps the compare off until prev_q has been loaded once after reset.
  assign pc_hit = prev_vld_q & (|((pin ^ prev_q) & pcmsk_q & PIN_MASK));

  always_comb begin
    ddr_d    = ddr_q;
    port_d   = port_q;
    pcmsk_d  = pcmsk_q;
    pcif_clr = 1'b0;
    if (wr_en) begin
      case (addr)
        IO_PIN:   port_d   = (port_q ^ wdata) & PIN_MASK;
        IO_DDR:   ddr_d    = wdata & PIN_MASK;
        IO_PORT:  port_d   = wdata & PIN_MASK;
        IO_PCMSK: pcmsk_d  = wdata & PIN_MASK;
        IO_PCIF:  pcif_clr = wdata[0];
        default:  ;
      endcase
    end
    // A detection in the same cycle as a clear leaves the flag set.
    if (pc_hit)        pcif_d = 1'b1;
    else if (pcif_clr) pcif_d = 1'b0;
    else               pcif_d = pcif_q;
  end

  // Read mux samples the registers before any same-cycle write lands.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (addr)
        IO_PIN:   rdata_d    = pin;
        IO_DDR:   rdata_d    = ddr_q;
        IO_PORT:  rdata_d    = port_q;
        IO_PCMSK: rdata_d    = pcmsk_q;
        IO_PCIF:  rdata_d[0] = pcif_q;
        default:  rdata_d    = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ddr_q      <= RESET_DDR & PIN_MASK;
      port_q     <= '0;
      pcmsk_q    <= '0;
      pcif_q     <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ddr_q      <= ddr_d;
      port_q     <= port_d;
      pcmsk_q    <= pcmsk_d;
      pcif_q     <= pcif_d;
      prev_q     <= pin;
      prev_vld_q <= 1'b1;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign pad_out    = port_q;
  assign pad_oe     = ddr_q;
  assign pad_pullup = ~ddr_q & port_q & {WIDTH{~pud}} & PIN_MASK;
  assign pcint_irq  = pcif_q;

endmodule

// File: tb/tb_avr_gpio_port.sv
// Self-checking bench for avr_gpio_port: a full 8-bit port and a 7-pin port
// share stimulus; register reads are checked through an expected-data queue.
module tb_avr_gpio_port;
  import avr_io_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   addr;
  logic         wr_en, rd_en, pud;
  logic [W-1:0] wdata, pad_in;
  logic [W-1:0] rdata, pad_out, pad_oe, pad_pullup;
  logic [W-1:0] rdata_m, pad_out_m, pad_oe_m, pad_pullup_m;
  logic         pcint_irq, pcint_irq_m;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W:0]   expm_q[$];
  logic         rd_seen = 1'b0;

  logic [W-1:0] m_ddr, m_port, m_pcmsk;
  logic         m_pcif;

  avr_gpio_port #(.WIDTH(W), .RESET_DDR(8'h0F)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .pud(pud), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oe(pad_oe), .pad_pullup(pad_pullup),
    .pcint_irq(pcint_irq)
  );

  avr_gpio_port #(.WIDTH(W), .PIN_MASK(8'h7F)) dut_m (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata_m), .pud(pud), .pad_in(pad_in),
    .pad_out(pad_out_m), .pad_oe(pad_oe_m), .pad_pullup(pad_pullup_m),
    .pcint_irq(pcint_irq_m)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: a read sampled at a posedge is checked on the following negedge
  always @(posedge clk) rd_seen <= rd_en;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", exp_q.size(), 1);
      end else begin
        logic [W-1:0] e;
        logic [W:0]   em;
        e  = exp_q.pop_front();
        em = expm_q.pop_front();
        chk("rdata", rdata, e);
        if (em[W]) chk("rdata_m", rdata_m, em[W-1:0]);
      end
    end
  end

  // drivers: every task starts and ends just after a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_ddr = 8'h0F; m_port = '0; m_pcmsk = '0; m_pcif = 1'b0;
  endtask

  task automatic model_wr(input logic [2:0] a, input logic [W-1:0] d);
    case (a)
      IO_PIN:   m_port  = m_port ^ d;
      IO_DDR:   m_ddr   = d;
      IO_PORT:  m_port  = d;
      IO_PCMSK: m_pcmsk = d;
      default:  ;
    endcase
  endtask

  function automatic logic [W-1:0] model_rd(input logic [2:0] a);
    case (a)
      IO_PIN:   return pad_in;
      IO_DDR:   return m_ddr;
      IO_PORT:  return m_port;
      IO_PCMSK: return m_pcmsk;
      IO_PCIF:  return {7'b0, m_pcif};
      default:  return '0;
    endcase
  endfunction

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_wr(a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [W-1:0] e,
                    input logic cm = 1'b0, input logic [W-1:0] em = '0);
    rd_en = 1'b1; addr = a;
    exp_q.push_back(e);
    expm_q.push_back({cm, em});
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wrrd(input logic [2:0] a, input logic [W-1:0] d, input logic [W-1:0] e);
    wr_en = 1'b1; rd_en = 1'b1; addr = a; wdata = d;
    exp_q.push_back(e);
    expm_q.push_back('0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    model_wr(a, d);
  endtask

  task automatic chk_pads(input string tag);
    chk({tag, "_oe"},  pad_oe,  m_ddr);
    chk({tag, "_out"}, pad_out, m_port);
    chk({tag, "_pu"},  pad_pullup, ~m_ddr & m_port & {W{~pud}});
  endtask

  initial begin
    // reset with a write held high: reset must win
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = IO_DDR; wdata = 8'hFF;
    pud = 1'b0; pad_in = '0;
    model_reset();
    tick(3);
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_oe", pad_oe, 8'h0F);
    chk("rst_out", pad_out, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_irq", pcint_irq, 1'b0);
    chk("rst_oe_m", pad_oe_m, 8'h00);
    tick(3);

    // DDR / PORT / pull-up
    wr(IO_DDR, 8'hF0);
    wr(IO_PORT, 8'hA5);
    chk("oe_f0", pad_oe, 8'hF0);
    chk("out_a5", pad_out, 8'hA5);
    chk("pu_05", pad_pullup, 8'h05);
    pud = 1'b1; #1;
    chk("pu_pud", pad_pullup, 8'h00);
    pud = 1'b0;
    tick(1);

    // PIN write toggles PORT
    wr(IO_PORT, 8'h3C);
    wr(IO_PIN, 8'hFF);
    rd(IO_PORT, 8'hC3);
    wr(IO_PIN, 8'h01);
    rd(IO_PORT, 8'hC2);

    // same-cycle write+read returns the old value
    wrrd(IO_PORT, 8'h55, 8'hC2);
    rd(IO_PORT, 8'h55);

    // unmapped addresses
    wr(3'd5, 8'hFF);
    wr(3'd7, 8'h12);
    rd(3'd5, 8'h00);
    rd(3'd7, 8'h00);
    chk_pads("unmapped");

    // pad-to-PIN and pad-to-irq latency
    wr(IO_PCMSK, 8'h40);
    wr(IO_PCIF, 8'h01);
    pad_in = 8'h40;
    tick(1);
    rd(IO_PIN, 8'h00);
    chk("irq_c2", pcint_irq, 1'b0);
    rd(IO_PIN, 8'h40);
    chk("irq_c3", pcint_irq, 1'b1);
    rd(IO_PCIF, 8'h01);
    rd(IO_PCIF, 8'h01);
    chk("irq_after_rd", pcint_irq, 1'b1);

    // unmasked change does not flag
    wr(IO_PCMSK, 8'h01);
    wr(IO_PCIF, 8'h01);
    chk("irq_clr", pcint_irq, 1'b0);
    pad_in = 8'h00;
    tick(4);
    chk("irq_unmasked", pcint_irq, 1'b0);
    rd(IO_PCIF, 8'h00);

    // set beats a same-cycle clear
    wr(IO_PCMSK, 8'h40);
    pad_in = 8'h40;
    tick(3);
    chk("irq_set", pcint_irq, 1'b1);
    pad_in = 8'h00;
    tick(2);
    wr(IO_PCIF, 8'h01);
    chk("irq_set_wins", pcint_irq, 1'b1);
    tick(1);
    wr(IO_PCIF, 8'hFE);
    chk("irq_bit0_only", pcint_irq, 1'b1);
    wr(IO_PCIF, 8'h01);
    chk("irq_late_clr", pcint_irq, 1'b0);

    // reset mid-detection
    pad_in = 8'h40;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    chk("rst2_irq", pcint_irq, 1'b0);
    tick(3);
    chk("rst2_irq_late", pcint_irq, 1'b0);
    chk_pads("rst2");

    // unimplemented bit 7 on the 7-pin port
    pad_in = 8'h15;
    tick(4);
    wr(IO_DDR, 8'hFF);
    wr(IO_PORT, 8'hFF);
    chk("m_oe", pad_oe_m, 8'h7F);
    chk("m_out", pad_out_m, 8'h7F);
    chk("m_pu", pad_pullup_m, 8'h00);
    chk("full_oe", pad_oe, 8'hFF);
    rd(IO_DDR, 8'hFF, 1'b1, 8'h7F);
    rd(IO_PORT, 8'hFF, 1'b1, 8'h7F);
    wr(IO_PCMSK, 8'hFF);
    wr(IO_PCIF, 8'h01);
    pad_in = 8'h95;
    tick(4);
    chk("m_irq_b7", pcint_irq_m, 1'b0);
    chk("full_irq_b7", pcint_irq, 1'b1);
    rd(IO_PIN, 8'h95, 1'b1, 8'h15);
    pad_in = 8'h15;
    tick(4);
    chk("m_irq_b7_back", pcint_irq_m, 1'b0);
    wr(IO_PCIF, 8'h01);
    m_pcif = 1'b0;
    chk("full_irq_clr", pcint_irq, 1'b0);

    // random register traffic with stable pads
    for (int i = 0; i < 24; i++) begin
      logic [2:0]   a, r;
      logic [W-1:0] d;
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      r = 3'($urandom_range(0, 7));
      wr(a, d);
      chk_pads("rnd");
      rd(r, model_rd(r));
    end

    tick(2);
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
